// File: rtl/next_pc_unit_pkg.sv
// Shared definitions for the next-PC unit: branch condition encodings and FSM states.
package next_pc_unit_pkg;

    localparam logic [2:0] FUNC_EQ  = 3'b000;
    localparam logic [2:0] FUNC_NE  = 3'b001;
    localparam logic [2:0] FUNC_LT  = 3'b100;
    localparam logic [2:0] FUNC_GE  = 3'b101;
    localparam logic [2:0] FUNC_LTU = 3'b110;
    localparam logic [2:0] FUNC_GEU = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/next_pc_unit_branch_cmp.sv
// Combinational branch condition evaluator; the 010/011 encodings never fire.
module branch_cmp
    import next_pc_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] comp1,
    input  logic [XLEN-1:0] comp2,
    input  logic [2:0]      func,
    output logic            cond
);

    always_comb begin
        cond = 1'b0;
        case (func)
            FUNC_EQ:  cond = (comp1 == comp2);
            FUNC_NE:  cond = (comp1 != comp2);
            FUNC_LT:  cond = ($signed(comp1) <  $signed(comp2));
            FUNC_GE:  cond = ($signed(comp1) >= $signed(comp2));
            FUNC_LTU: cond = (comp1 <  comp2);
            FUNC_GEU: cond = (comp1 >= comp2);
            default:  cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC unit: after DELAY_CYCLES non-stalled WAIT edges, registers the
// sequential or branch target PC and pulses pc_valid for one cycle.
module next_pc_unit
    import next_pc_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int INC          = 4,
    parameter int DELAY_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            execute,
    input  logic            stall,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] comp1,
    input  logic [XLEN-1:0] comp2,
    input  logic [2:0]      func,
    input  logic            branch_en,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_valid,
    output logic            taken
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   pc_next_q, pc_next_d;
    logic              taken_q, taken_d;
    logic              pc_valid_q, pc_valid_d;
    logic              cond;
    logic              br_taken;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .comp1 (comp1),
        .comp2 (comp2),
        .func  (func),
        .cond  (cond)
    );

    assign br_taken = branch_en & cond;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_next_d  = pc_next_q;
        taken_d    = taken_q;
        pc_valid_d = 1'b0;
        // Dropping execute wins over everything, including stall.
        if (!execute) begin
            state_d   = IDLE;
            cnt_d     = '0;
            pc_next_d = '0;
            taken_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
                WAIT: begin
                    if (!stall) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d      = '0;
                            taken_d    = br_taken;
                            pc_next_d  = br_taken ? (pc_in + imm) : (pc_in + XLEN'(INC));
                            pc_valid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pc_next_q  <= '0;
            taken_q    <= 1'b0;
            pc_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_next_q  <= pc_next_d;
            taken_q    <= taken_d;
            pc_valid_q <= pc_valid_d;
        end
    end

    assign pc_next  = pc_next_q;
    assign pc_valid = pc_valid_q;
    assign taken    = taken_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: vector table, directed multi-cycle
// sequences, a 16-bit single-cycle instance, and random traffic vs. a model.
module tb_next_pc_unit;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        nrst;
    logic        execute, stall, branch_en;
    logic [31:0] pc_in, comp1, comp2, imm;
    logic [2:0]  func;
    logic [31:0] pc_next;
    logic        pc_valid, taken;

    logic        execute_b, stall_b;
    logic [15:0] pc_in_b, pc_next_b;
    logic        pc_valid_b, taken_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    next_pc_unit #(.XLEN(32), .INC(4), .DELAY_CYCLES(D), .CNT_W(8)) dut (
        .clk(clk), .nrst(nrst), .execute(execute), .stall(stall),
        .pc_in(pc_in), .comp1(comp1), .comp2(comp2), .func(func),
        .branch_en(branch_en), .imm(imm),
        .pc_next(pc_next), .pc_valid(pc_valid), .taken(taken)
    );

    next_pc_unit #(.XLEN(16), .INC(4), .DELAY_CYCLES(1), .CNT_W(8)) dut_b (
        .clk(clk), .nrst(nrst), .execute(execute_b), .stall(stall_b),
        .pc_in(pc_in_b), .comp1(16'h0), .comp2(16'h0), .func(3'b000),
        .branch_en(1'b0), .imm(16'h0),
        .pc_next(pc_next_b), .pc_valid(pc_valid_b), .taken(taken_b)
    );

    typedef struct {
        logic [31:0] c1, c2, im, pc;
        logic [2:0]  f;
        logic        be;
        logic        exp_tk;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until pc_valid is seen, at most 8 edges.
    task automatic wait_pulse(input string nm);
        bit seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (pc_valid) seen = 1;
        end
        chk({nm, "_pulse_timeout"}, {63'd0, seen}, 64'd1);
    endtask

    function automatic bit ref_cond(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        case (f)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return sa <  sb;
            3'd5: return sa >= sb;
            3'd6: return ua <  ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic vec_t mk(input logic [31:0] c1, c2, im, pc, input logic [2:0] f,
                                input logic be, exp_tk, input logic [31:0] exp_pc);
        vec_t v;
        v.c1 = c1; v.c2 = c2; v.im = im; v.pc = pc; v.f = f; v.be = be;
        v.exp_tk = exp_tk; v.exp_pc = exp_pc;
        return v;
    endfunction

    initial begin
        bit          m_idle;
        int          m_n;
        logic [31:0] m_pc;
        logic        m_tk, m_vld;
        logic [15:0] exp_b;
        bit          stall_pat[6] = '{0, 0, 1, 0, 0, 0};

        vecs.push_back(mk(32'hFFFFFFFF, 32'h1, 32'hFFFFFFF0, 32'h40, 3'b100, 1, 1, 32'h30));
        vecs.push_back(mk(32'hFFFFFFFF, 32'h1, 32'hFFFFFFF0, 32'h40, 3'b110, 1, 0, 32'h44));
        vecs.push_back(mk(32'h0, 32'h0, 32'h0, 32'hFFFFFFFC, 3'b000, 0, 0, 32'h0));
        vecs.push_back(mk(32'h1234, 32'h1234, 32'h100, 32'h1000, 3'b000, 1, 1, 32'h1100));
        vecs.push_back(mk(32'h1234, 32'h1234, 32'h100, 32'h1000, 3'b001, 1, 0, 32'h1004));
        vecs.push_back(mk(32'h1, 32'h2, 32'h100, 32'h1000, 3'b010, 1, 0, 32'h1004));
        vecs.push_back(mk(32'h1, 32'h2, 32'h100, 32'h1000, 3'b011, 1, 0, 32'h1004));
        vecs.push_back(mk(32'h5, 32'hFFFFFFFB, 32'h8, 32'h200, 3'b101, 1, 1, 32'h208));
        vecs.push_back(mk(32'h5, 32'hFFFFFFFB, 32'h8, 32'h200, 3'b111, 1, 0, 32'h204));
        vecs.push_back(mk(32'h7, 32'h7, 32'h8, 32'h200, 3'b000, 0, 0, 32'h204));
        vecs.push_back(mk(32'h1, 32'h2, 32'h20, 32'hFFFFFFF0, 3'b001, 1, 1, 32'h10));

        nrst = 1'b1; execute = 1'b1; stall = 1'b0; branch_en = 1'b0;
        pc_in = 32'h100; comp1 = '0; comp2 = '0; imm = '0; func = '0;
        execute_b = 1'b0; stall_b = 1'b0; pc_in_b = '0;

        // Asynchronous reset before any clock edge.
        #2 nrst = 1'b0;
        #1;
        chk("rst_pc_next", {32'd0, pc_next}, 64'd0);
        chk("rst_taken", {63'd0, taken}, 64'd0);
        chk("rst_valid", {63'd0, pc_valid}, 64'd0);
        chk("rst_b_valid", {63'd0, pc_valid_b}, 64'd0);

        // Edge 0 occurs in reset; execute first sampled at edge 1.
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk($sformatf("seq_valid_e%0d", e), {63'd0, pc_valid}, {63'd0, (e == 3 || e == 5)});
            if (e == 3) begin
                chk("seq_pc_e3", {32'd0, pc_next}, 64'h104);
                chk("seq_taken_e3", {63'd0, taken}, 64'd0);
            end
        end

        foreach (vecs[i]) begin
            comp1 = vecs[i].c1; comp2 = vecs[i].c2; imm = vecs[i].im;
            pc_in = vecs[i].pc; func = vecs[i].f; branch_en = vecs[i].be;
            wait_pulse($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_taken", i), {63'd0, taken}, {63'd0, vecs[i].exp_tk});
            chk($sformatf("vec%0d_pc", i), {32'd0, pc_next}, {32'd0, vecs[i].exp_pc});
        end

        // Stall for 3 edges while cnt=1; inputs changed mid-stall must be used at capture.
        tick();
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("stall_valid%0d", s), {63'd0, pc_valid}, 64'd0);
            chk($sformatf("stall_pc%0d", s), {32'd0, pc_next}, 64'h10);
            pc_in = 32'h500; branch_en = 1'b0;
        end
        stall = 1'b0;
        tick();
        chk("stall_release_valid", {63'd0, pc_valid}, 64'd1);
        chk("stall_release_pc", {32'd0, pc_next}, 64'h504);

        // execute drop during a stall clears everything.
        tick();
        stall = 1'b1; execute = 1'b0;
        tick();
        chk("exec0_pc", {32'd0, pc_next}, 64'd0);
        chk("exec0_taken", {63'd0, taken}, 64'd0);
        chk("exec0_valid", {63'd0, pc_valid}, 64'd0);
        stall = 1'b0; execute = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("restart_valid%0d", e), {63'd0, pc_valid}, {63'd0, e == 3});
        end
        chk("restart_pc", {32'd0, pc_next}, 64'h504);

        // Reset pulse between edges mid-WAIT.
        tick();
        #2 nrst = 1'b0;
        #1;
        chk("midrst_pc", {32'd0, pc_next}, 64'd0);
        chk("midrst_valid", {63'd0, pc_valid}, 64'd0);
        chk("midrst_taken", {63'd0, taken}, 64'd0);
        #1 nrst = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("postrst_valid%0d", e), {63'd0, pc_valid}, {63'd0, e == 3});
        end
        chk("postrst_pc", {32'd0, pc_next}, 64'h504);

        // Single-cycle 16-bit instance, stepping through the wrap.
        execute_b = 1'b1; pc_in_b = 16'hFFF8;
        tick();
        chk("b_enter_valid", {63'd0, pc_valid_b}, 64'd0);
        exp_b = 16'h0;
        foreach (stall_pat[i]) begin
            stall_b = stall_pat[i];
            tick();
            if (!stall_pat[i]) begin
                exp_b = pc_in_b + 16'd4;
                chk($sformatf("b_valid%0d", i), {63'd0, pc_valid_b}, 64'd1);
                chk($sformatf("b_pc%0d", i), {48'd0, pc_next_b}, {48'd0, exp_b});
                pc_in_b = exp_b;
            end else begin
                chk($sformatf("b_stall_valid%0d", i), {63'd0, pc_valid_b}, 64'd0);
                chk($sformatf("b_stall_pc%0d", i), {48'd0, pc_next_b}, {48'd0, exp_b});
            end
        end
        execute_b = 1'b0;

        // Random traffic: pulse on every D-th non-stalled WAIT edge since entry.
        execute = 1'b0; stall = 1'b0;
        tick();
        m_idle = 1; m_n = 0; m_pc = '0; m_tk = 0;
        for (int c = 0; c < 400; c++) begin
            execute   = ($urandom_range(0, 19) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            comp1     = $urandom;
            comp2     = ($urandom_range(0, 3) == 0) ? comp1 : $urandom;
            func      = 3'($urandom);
            branch_en = 1'($urandom);
            imm       = $urandom;
            pc_in     = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
            m_vld = 0;
            if (!execute) begin
                m_idle = 1; m_n = 0; m_pc = '0; m_tk = 0;
            end else if (m_idle) begin
                m_idle = 0; m_n = 0;
            end else if (!stall) begin
                m_n++;
                if (m_n % D == 0) begin
                    m_tk  = branch_en && ref_cond(comp1, comp2, func);
                    m_pc  = m_tk ? pc_in + imm : pc_in + 32'd4;
                    m_vld = 1;
                end
            end
            tick();
            chk($sformatf("rnd%0d_valid", c), {63'd0, pc_valid}, {63'd0, m_vld});
            chk($sformatf("rnd%0d_taken", c), {63'd0, taken}, {63'd0, m_tk});
            chk($sformatf("rnd%0d_pc", c), {32'd0, pc_next}, {32'd0, m_pc});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
